// File: rtl/spi_slave_gen.sv
// spi_slave_gen: SPI frame slave decoding a 2-bit command, with a
// read-address / read-data handshake that returns memory data on MISO.
`default_nettype none

module spi_slave_gen #(
  parameter int DATA_W  = 8,
  parameter int TX_WAIT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_timeout
);

  localparam int F      = DATA_W + 2;
  localparam int CNT_W  = $clog2(F + 1);
  localparam int WAIT_W = $clog2(TX_WAIT + 1);
  localparam int TXC_W  = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_t;

  // Sub-phases of READ_DATA once its command frame has been received.
  typedef enum logic [1:0] {
    PH_WAIT  = 2'd0,
    PH_SHIFT = 2'd1,
    PH_HOLD  = 2'd2
  } phase_t;

  state_t            state_q, state_d;
  phase_t            phase_q, phase_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [F-2:0]      shift_q, shift_d;
  logic [F-1:0]      rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              miso_q, miso_d;
  logic              tx_timeout_q, tx_timeout_d;
  logic              rd_addr_done_q, rd_addr_done_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic [TXC_W-1:0]  tx_cnt_q, tx_cnt_d;
  logic              frame_last;
  logic              frame_done;

  assign frame_last = (bit_cnt_q == CNT_W'(F - 1));
  assign frame_done = (bit_cnt_q == CNT_W'(F));

  always_comb begin
    state_d        = state_q;
    phase_d        = phase_q;
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    miso_d         = miso_q;
    tx_timeout_d   = 1'b0;
    rd_addr_done_d = rd_addr_done_q;
    wait_cnt_d     = wait_cnt_q;
    tx_shift_d     = tx_shift_q;
    tx_cnt_d       = tx_cnt_q;

    case (state_q)
      IDLE: begin
        miso_d     = 1'b0;
        bit_cnt_d  = '0;
        wait_cnt_d = '0;
        tx_cnt_d   = '0;
        phase_d    = PH_WAIT;
        if (!SS_n) begin
          state_d = CHK_CMD;
        end
      end

      default: begin
        if (SS_n) begin
          // Deselect aborts everything; a partial frame leaves rx_data alone.
          state_d    = IDLE;
          miso_d     = 1'b0;
          bit_cnt_d  = '0;
          wait_cnt_d = '0;
          tx_cnt_d   = '0;
          phase_d    = PH_WAIT;
        end else if (state_q == CHK_CMD) begin
          shift_d   = {shift_q[F-3:0], MOSI};
          bit_cnt_d = CNT_W'(1);
          if (!MOSI) begin
            state_d = WRITE;
          end else if (rd_addr_done_q) begin
            state_d = READ_DATA;
          end else begin
            state_d = READ_ADD;
          end
        end else if (!frame_done) begin
          shift_d   = {shift_q[F-3:0], MOSI};
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (frame_last) begin
            rx_data_d  = {shift_q, MOSI};
            rx_valid_d = 1'b1;
            if (state_q == READ_ADD) begin
              rd_addr_done_d = 1'b1;
            end
          end
        end else if (state_q == READ_DATA) begin
          case (phase_q)
            PH_WAIT: begin
              // The timeout fires on the TX_WAIT-th sampling edge without tx_valid.
              if (tx_valid) begin
                tx_shift_d = tx_data;
                tx_cnt_d   = '0;
                phase_d    = PH_SHIFT;
              end else if (wait_cnt_q == WAIT_W'(TX_WAIT - 1)) begin
                tx_timeout_d   = 1'b1;
                rd_addr_done_d = 1'b0;
                miso_d         = 1'b0;
                phase_d        = PH_HOLD;
              end else begin
                wait_cnt_d = wait_cnt_q + WAIT_W'(1);
              end
            end
            PH_SHIFT: begin
              if (tx_cnt_q == TXC_W'(DATA_W)) begin
                miso_d         = 1'b0;
                rd_addr_done_d = 1'b0;
                phase_d        = PH_HOLD;
              end else begin
                miso_d     = tx_shift_q[DATA_W-1];
                tx_shift_d = tx_shift_q << 1;
                tx_cnt_d   = tx_cnt_q + TXC_W'(1);
              end
            end
            default: begin
              miso_d = 1'b0;
            end
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      phase_q        <= PH_WAIT;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      miso_q         <= 1'b0;
      tx_timeout_q   <= 1'b0;
      rd_addr_done_q <= 1'b0;
      wait_cnt_q     <= '0;
      tx_shift_q     <= '0;
      tx_cnt_q       <= '0;
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      miso_q         <= miso_d;
      tx_timeout_q   <= tx_timeout_d;
      rd_addr_done_q <= rd_addr_done_d;
      wait_cnt_q     <= wait_cnt_d;
      tx_shift_q     <= tx_shift_d;
      tx_cnt_q       <= tx_cnt_d;
    end
  end

  assign MISO       = miso_q;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign tx_timeout = tx_timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_slave_gen.sv
// Bench for spi_slave_gen: directed scenarios plus randomized frames against
// a frame-level model of command routing and the read-data return path.
`default_nettype none

module tb_spi_slave_gen;
  localparam int DATA_W  = 8;
  localparam int TX_WAIT = 4;
  localparam int F       = DATA_W + 2;
  localparam int OBS     = TX_WAIT + DATA_W + 3;

  logic              clk = 1'b0;
  logic              rst_n, SS_n, MOSI, MISO, rx_valid, tx_valid, tx_timeout;
  logic [F-1:0]      rx_data;
  logic [DATA_W-1:0] tx_data;

  int checks = 0;
  int errors = 0;

  // Model state: whether a read address is pending, and the last full frame.
  bit           rd_done_m;
  logic [F-1:0] last_rx_m;

  always #5 clk = ~clk;

  spi_slave_gen #(.DATA_W(DATA_W), .TX_WAIT(TX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_timeout(tx_timeout)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Select, then send the first nbits of fr MSB first; records rx_valid pulses.
  task automatic shift_frame(input logic [F-1:0] fr, input int nbits,
                             output int pulses, output int pulse_at);
    pulses   = 0;
    pulse_at = -1;
    SS_n     = 1'b0;
    MOSI     = 1'($urandom);
    tx_valid = 1'($urandom);
    tx_data  = DATA_W'($urandom);
    step();
    if (rx_valid) begin pulses++; pulse_at = -2; end
    for (int i = 0; i < nbits; i++) begin
      MOSI     = fr[F-1-i];
      tx_valid = 1'($urandom);
      tx_data  = DATA_W'($urandom);
      step();
      if (rx_valid) begin pulses++; pulse_at = i; end
    end
  endtask

  // After a completed frame: tx_valid rises at wait edge valid_at (never if <0)
  // presenting d, then stays high with junk data. Traces MISO/tx_timeout/rx_valid.
  task automatic observe(input int valid_at, input logic [DATA_W-1:0] d,
                         output logic [OBS-1:0] mt, output logic [OBS-1:0] tt,
                         output logic [OBS-1:0] vt);
    for (int j = 0; j < OBS; j++) begin
      tx_valid = (valid_at >= 0) && (j >= valid_at);
      tx_data  = (j == valid_at) ? d : DATA_W'($urandom);
      MOSI     = 1'($urandom);
      step();
      mt[j] = MISO;
      tt[j] = tx_timeout;
      vt[j] = rx_valid;
    end
    tx_valid = 1'b0;
  endtask

  task automatic end_frame();
    SS_n     = 1'b1;
    tx_valid = 1'b0;
    step();
  endtask

  function automatic logic [OBS-1:0] exp_miso(input bit is_rd, input int valid_at,
                                              input logic [DATA_W-1:0] d);
    logic [OBS-1:0] m;
    m = '0;
    if (is_rd && valid_at >= 0 && valid_at < TX_WAIT)
      for (int b = 0; b < DATA_W; b++) m[valid_at+1+b] = d[DATA_W-1-b];
    return m;
  endfunction

  function automatic logic [OBS-1:0] exp_to(input bit is_rd, input int valid_at);
    logic [OBS-1:0] t;
    t = '0;
    if (is_rd && (valid_at < 0 || valid_at >= TX_WAIT)) t[TX_WAIT-1] = 1'b1;
    return t;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = '0;
    step(); step();
    checks++; if (MISO !== 1'b0) begin errors++; $display("FAIL reset MISO got %b need 0", MISO); end
    checks++; if (rx_data !== '0) begin errors++; $display("FAIL reset rx_data got %h need 000", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset rx_valid got %b need 0", rx_valid); end
    checks++; if (tx_timeout !== 1'b0) begin errors++; $display("FAIL reset tx_timeout got %b need 0", tx_timeout); end
    rst_n = 1'b1;
    step();
    rd_done_m = 1'b0;
    last_rx_m = '0;
  endtask

  task automatic test_write();
    int p, pa;
    logic [F-1:0] fr;
    logic [OBS-1:0] mt, tt, vt;
    for (int n = 0; n < 4; n++) begin
      fr = (n == 0) ? F'(10'h0AA) : {2'b00, DATA_W'($urandom)};
      shift_frame(fr, F, p, pa);
      checks++; if (p != 1 || pa != F-1) begin errors++; $display("FAIL write pulse n=%0d got count %0d at %0d need 1 at %0d", n, p, pa, F-1); end
      checks++; if (rx_data !== fr) begin errors++; $display("FAIL write rx_data n=%0d got %h need %h", n, rx_data, fr); end
      last_rx_m = fr;
      observe(0, DATA_W'($urandom), mt, tt, vt);
      checks++; if (vt !== '0 || rx_data !== fr || mt !== '0) begin errors++; $display("FAIL write hold n=%0d rx_valid %h rx_data %h MISO %h need 0 %h 0", n, vt, rx_data, mt, fr); end
      end_frame();
    end
  endtask

  task automatic test_abort();
    int p, pa;
    logic [F-1:0] fr;
    logic [DATA_W-1:0] d;
    logic [OBS-1:0] mt, tt, vt;
    for (int n = 0; n < 2; n++) begin
      fr = {(n == 0) ? 2'b00 : 2'b10, DATA_W'($urandom)};
      shift_frame(fr, 5 + n, p, pa);
      end_frame();
      checks++; if (p != 0 || rx_valid !== 1'b0 || rx_data !== last_rx_m) begin errors++; $display("FAIL abort n=%0d pulses %0d rx_valid %b rx_data %h need 0 0 %h", n, p, rx_valid, rx_data, last_rx_m); end
    end
    // Aborted read-address frame must not arm READ_DATA.
    fr = {2'b11, DATA_W'($urandom)};
    shift_frame(fr, F, p, pa);
    last_rx_m = fr;
    observe(0, DATA_W'($urandom), mt, tt, vt);
    checks++; if (mt !== '0 || tt !== '0) begin errors++; $display("FAIL abort readadd MISO %h timeout %h need 0 0", mt, tt); end
    end_frame();
    rd_done_m = 1'b1;
    // Deselect mid-transmission keeps the read address armed.
    fr = {2'b11, DATA_W'($urandom)};
    shift_frame(fr, F, p, pa);
    last_rx_m = fr;
    d = DATA_W'($urandom);
    tx_valid = 1'b1; tx_data = d;
    step();
    tx_valid = 1'b0;
    step(); step(); step();
    checks++; if (MISO !== d[DATA_W-3]) begin errors++; $display("FAIL abort midtx bit got %b need %b", MISO, d[DATA_W-3]); end
    end_frame();
    checks++; if (MISO !== 1'b0) begin errors++; $display("FAIL abort midtx MISO got %b need 0", MISO); end
    fr = {2'b10, DATA_W'($urandom)};
    d  = DATA_W'($urandom);
    shift_frame(fr, F, p, pa);
    last_rx_m = fr;
    observe(0, d, mt, tt, vt);
    checks++; if (mt !== exp_miso(1'b1, 0, d)) begin errors++; $display("FAIL abort rearmed MISO got %h need %h", mt, exp_miso(1'b1, 0, d)); end
    end_frame();
    rd_done_m = 1'b0;
  endtask

  task automatic test_read();
    int p, pa;
    logic [OBS-1:0] mt, tt, vt, em;
    shift_frame(F'(10'h205), F, p, pa);
    checks++; if (p != 1 || rx_data !== F'(10'h205)) begin errors++; $display("FAIL read addr rx_data got %h pulses %0d need 205 1", rx_data, p); end
    observe(0, DATA_W'($urandom), mt, tt, vt);
    end_frame();
    shift_frame(F'(10'h300), F, p, pa);
    checks++; if (p != 1 || rx_data !== F'(10'h300)) begin errors++; $display("FAIL read data rx_data got %h pulses %0d need 300 1", rx_data, p); end
    observe(0, 8'hC3, mt, tt, vt);
    em = '0;
    em[8:1] = 8'b11000011;
    checks++; if (mt !== em) begin errors++; $display("FAIL read C3 MISO trace got %h need %h", mt, em); end
    checks++; if (tt !== '0) begin errors++; $display("FAIL read C3 timeout got %h need 0", tt); end
    end_frame();
    // rd_addr_done now clear: cmd 11 is an address, the next cmd 11 returns data.
    shift_frame(F'(10'h3A5), F, p, pa);
    checks++; if (rx_data !== F'(10'h3A5)) begin errors++; $display("FAIL read cmd11 rx_data got %h need 3a5", rx_data); end
    observe(0, DATA_W'($urandom), mt, tt, vt);
    checks++; if (mt !== '0) begin errors++; $display("FAIL read cmd11 as address MISO got %h need 0", mt); end
    end_frame();
    shift_frame(F'(10'h3FF), F, p, pa);
    observe(1, 8'h5A, mt, tt, vt);
    checks++; if (mt !== exp_miso(1'b1, 1, 8'h5A)) begin errors++; $display("FAIL read cmd11 data MISO got %h need %h", mt, exp_miso(1'b1, 1, 8'h5A)); end
    end_frame();
    rd_done_m = 1'b0;
    last_rx_m = F'(10'h3FF);
  endtask

  task automatic test_timeout();
    int p, pa;
    logic [OBS-1:0] mt, tt, vt, et;
    shift_frame(F'(10'h211), F, p, pa);
    observe(-1, '0, mt, tt, vt);
    end_frame();
    shift_frame(F'(10'h3C0), F, p, pa);
    observe(-1, '0, mt, tt, vt);
    et = '0;
    et[TX_WAIT-1] = 1'b1;
    checks++; if (tt !== et) begin errors++; $display("FAIL timeout trace got %h need %h", tt, et); end
    checks++; if (mt !== '0) begin errors++; $display("FAIL timeout MISO got %h need 0", mt); end
    end_frame();
    shift_frame(F'(10'h301), F, p, pa);
    observe(0, 8'hFF, mt, tt, vt);
    checks++; if (mt !== '0 || tt !== '0) begin errors++; $display("FAIL timeout cleared flag MISO %h timeout %h need 0 0", mt, tt); end
    end_frame();
    rd_done_m = 1'b1;
    last_rx_m = F'(10'h301);
  endtask

  task automatic test_reset_mid();
    int p, pa;
    logic [OBS-1:0] mt, tt, vt;
    shift_frame(F'(10'h3E7), F, p, pa);
    tx_valid = 1'b1; tx_data = 8'hFF;
    step();
    tx_valid = 1'b0;
    step(); step();
    checks++; if (MISO !== 1'b1) begin errors++; $display("FAIL resetmid pre MISO got %b need 1", MISO); end
    rst_n = 1'b0;
    step();
    checks++; if (MISO !== 1'b0 || rx_valid !== 1'b0 || rx_data !== '0 || tx_timeout !== 1'b0) begin errors++; $display("FAIL resetmid outputs MISO %b rx_valid %b rx_data %h tx_timeout %b need 0 0 000 0", MISO, rx_valid, rx_data, tx_timeout); end
    rst_n = 1'b1;
    end_frame();
    rd_done_m = 1'b0;
    last_rx_m = '0;
    shift_frame(F'(10'h3E7), F, p, pa);
    observe(0, 8'hFF, mt, tt, vt);
    checks++; if (mt !== '0) begin errors++; $display("FAIL resetmid flag cleared MISO got %h need 0", mt); end
    end_frame();
    rd_done_m = 1'b1;
    last_rx_m = F'(10'h3E7);
  endtask

  task automatic test_back_to_back();
    int p, pa, va, nb;
    bit is_rd;
    logic [F-1:0] fr;
    logic [DATA_W-1:0] d;
    logic [OBS-1:0] mt, tt, vt;
    for (int n = 0; n < 30; n++) begin
      fr    = F'($urandom);
      nb    = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, F-1)) : F;
      is_rd = fr[F-1] && rd_done_m;
      shift_frame(fr, nb, p, pa);
      if (nb < F) begin
        end_frame();
        checks++; if (p != 0 || rx_valid !== 1'b0 || rx_data !== last_rx_m) begin errors++; $display("FAIL b2b partial n=%0d pulses %0d rx_data %h need 0 %h", n, p, rx_data, last_rx_m); end
      end else begin
        checks++; if (p != 1 || pa != F-1) begin errors++; $display("FAIL b2b pulse n=%0d count %0d at %0d need 1 at %0d", n, p, pa, F-1); end
        checks++; if (rx_data !== fr) begin errors++; $display("FAIL b2b rx_data n=%0d got %h need %h", n, rx_data, fr); end
        last_rx_m = fr;
        va = int'($urandom_range(0, TX_WAIT + 2)) - 1;
        d  = DATA_W'($urandom);
        observe(va, d, mt, tt, vt);
        checks++; if (mt !== exp_miso(is_rd, va, d)) begin errors++; $display("FAIL b2b MISO n=%0d got %h need %h", n, mt, exp_miso(is_rd, va, d)); end
        checks++; if (tt !== exp_to(is_rd, va)) begin errors++; $display("FAIL b2b timeout n=%0d got %h need %h", n, tt, exp_to(is_rd, va)); end
        checks++; if (vt !== '0 || rx_data !== fr) begin errors++; $display("FAIL b2b hold n=%0d rx_valid %h rx_data %h need 0 %h", n, vt, rx_data, fr); end
        if (is_rd) rd_done_m = 1'b0;
        else if (fr[F-1]) rd_done_m = 1'b1;
        end_frame();
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_abort();
    test_read();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired after 500000 time units");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/spi_slave_gen.md
SPI_SLAVE_GEN -- requirements
Module: spi_slave_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 8: payload bits per frame; frame length F = DATA_W+2 (2 command bits + payload).
REQ-002 SHALL have parameter TX_WAIT, default 16: maximum cycles to wait for tx_valid in a read-data frame.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port SS_n  input  1  slave select, active-low; frame is active while low.
REQ-006 SHALL have port MOSI  input  1  serial data in, MSB first.
REQ-007 SHALL have port MISO  output  1  serial data out, registered.
REQ-008 SHALL have port rx_data  output  F  last complete received frame {cmd[1:0], payload}.
REQ-009 SHALL have port rx_valid  output  1  one-cycle pulse: rx_data updated.
REQ-010 SHALL have port tx_data  input  DATA_W  read data from the memory side.
REQ-011 SHALL have port tx_valid  input  1  tx_data valid; sampled only while waiting for read data.
REQ-012 SHALL have port tx_timeout  output  1  one-cycle pulse: read data did not arrive within TX_WAIT cycles.

Function
REQ-013 SHALL implement states IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, plus an internal flag rd_addr_done.
REQ-014 IDLE: MISO=0, bit counter cleared; SS_n=0 -> CHK_CMD next cycle.
REQ-015 CHK_CMD: sample MOSI as frame bit F-1. MOSI=0 -> WRITE; MOSI=1 and rd_addr_done=0 -> READ_ADD; MOSI=1 and rd_addr_done=1 -> READ_DATA.
REQ-016 WRITE, READ_ADD, READ_DATA: shift in the remaining F-1 bits, one per edge while SS_n=0, MSB first.
REQ-017 On the edge that samples frame bit 0: load rx_data with the full frame and set rx_valid. rx_valid is visible the next cycle and stays high exactly one cycle.
REQ-018 Completion of a READ_ADD frame SHALL set rd_addr_done.
REQ-019 READ_DATA, after its frame completes: wait for tx_valid=1 and latch tx_data on that edge. On the following DATA_W edges, drive MISO = tx_data[DATA_W-1] down to tx_data[0], one bit per cycle.
REQ-020 READ_DATA, after the last MISO bit: drive MISO=0, clear rd_addr_done, and hold in READ_DATA until SS_n=1.
REQ-021 READ_DATA wait timeout: if tx_valid is not seen within TX_WAIT cycles after frame completion, pulse tx_timeout for one cycle, keep MISO=0, clear rd_addr_done, and hold until SS_n=1.
REQ-022 SS_n=1 in any non-IDLE state SHALL force IDLE next cycle. A partial frame is discarded: no rx_valid, rx_data unchanged, counter cleared. rd_addr_done is unchanged unless REQ-020 or REQ-021 already applied.
REQ-023 tx_valid outside the read-data wait window SHALL be ignored.
REQ-024 Once a frame completes in WRITE or READ_ADD, further edges with SS_n=0 SHALL NOT shift or pulse rx_valid until SS_n returns high.
REQ-025 Bit counter width SHALL be ceil(log2(F+1)); TX_WAIT counter width SHALL be ceil(log2(TX_WAIT+1)); no wrap-around is permitted.

Reset
REQ-026 On a clk edge with rst_n=0: state=IDLE, MISO=0, rx_data=0, rx_valid=0, tx_timeout=0, rd_addr_done=0, all counters=0.
REQ-027 Reset SHALL take priority over every other event, including mid-frame and mid-transmission; no rx_valid or tx_timeout pulse results.

Verification (DATA_W=8, TX_WAIT=4)
REQ-028 Write frame 00_10101010 with SS_n low -> rx_data=0x0AA; rx_valid high one cycle, the cycle after the 10th bit edge.
REQ-029 Read-address frame 10_00000101, SS_n high, then frame 11_00000000 with tx_valid=1, tx_data=0xC3 -> MISO sequence 1,1,0,0,0,0,1,1, then 0; rd_addr_done=0.
REQ-030 Frame with cmd 11 after reset (rd_addr_done=0) -> handled as READ_ADD; rx_data=0x3xx; next cmd-11 frame enters READ_DATA.
REQ-031 SS_n raised after 5 bits of a write frame -> IDLE next cycle; no rx_valid; rx_data holds its previous value.
REQ-032 READ_DATA frame with tx_valid held 0 -> tx_timeout pulse on the 4th wait cycle; MISO stays 0; rd_addr_done=0.
REQ-033 rst_n=0 during MISO shifting -> next cycle: MISO=0, state IDLE, all outputs at reset values.
